kf8237_bus_initiator: RTL and testbench

- CPU-side bus initiator that drives the 8237 register interface.
- Generates chip-select, I/O read and I/O write strobe cycles with the setup and hold timing the DMA bus-control logic needs: the DMA samples on negedge, and a write commits on the strobe's rising edge.
- Supports three commands: a full channel-programming sequence, a single register write, and a single register read.
- Sits between the system sequencer/BIOS-emulation logic and the KF8237 bus port.

---
 rtl/kf8237_pkg.sv | 81 ++++++++
 rtl/kf8237_bus_initiator_if.sv | 20 ++
 rtl/kf8237_bus_cycle.sv | 83 ++++++++
 rtl/kf8237_bus_initiator.sv | 107 ++++++++++
 tb/tb_kf8237_bus_initiator.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kf8237_pkg.sv
// Shared definitions for the KF8237 CPU-side bus initiator: command codes,
// register offsets, phase/sequencer states and the PROGRAM_CHANNEL step table.
package kf8237_pkg;

  typedef enum logic [1:0] {
    CMD_PROGRAM_CHANNEL = 2'b00,
    CMD_WRITE_REG       = 2'b01,
    CMD_READ_REG        = 2'b10,
    CMD_RESERVED        = 2'b11
  } command_e;

  localparam logic [3:0] REG_COMMAND            = 4'h8;
  localparam logic [3:0] REG_REQUEST            = 4'h9;
  localparam logic [3:0] REG_SINGLE_MASK        = 4'hA;
  localparam logic [3:0] REG_MODE               = 4'hB;
  localparam logic [3:0] REG_CLEAR_BYTE_POINTER = 4'hC;
  localparam logic [3:0] REG_MASTER_CLEAR       = 4'hD;
  localparam logic [3:0] REG_CLEAR_MASK         = 4'hE;
  localparam logic [3:0] REG_ALL_MASK           = 4'hF;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_SETUP,
    PH_STROBE,
    PH_HOLD,
    PH_GAP
  } phase_e;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_RUN,
    SEQ_DONE
  } seq_e;

  typedef struct packed {
    command_e    command;
    logic [1:0]  channel;
    logic [7:0]  mode;
    logic [15:0] base_address;
    logic [15:0] word_count;
    logic        unmask;
    logic [3:0]  reg_address;
    logic [7:0]  reg_write_data;
  } request_t;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } access_t;

  // Register offset and data byte presented on the bus for a given step.
  function automatic access_t step_access(input request_t r, input logic [2:0] step);
    access_t a;
    a = '{addr: 4'h0, data: 8'h00};
    case (r.command)
      CMD_PROGRAM_CHANNEL: begin
        case (step)
          3'd0:    a = '{addr: REG_SINGLE_MASK,           data: {5'b0, 1'b1, r.channel}};
          3'd1:    a = '{addr: REG_CLEAR_BYTE_POINTER,    data: 8'h00};
          3'd2:    a = '{addr: REG_MODE,                  data: {r.mode[7:2], r.channel}};
          3'd3:    a = '{addr: {1'b0, r.channel, 1'b0},   data: r.base_address[7:0]};
          3'd4:    a = '{addr: {1'b0, r.channel, 1'b0},   data: r.base_address[15:8]};
          3'd5:    a = '{addr: {1'b0, r.channel, 1'b1},   data: r.word_count[7:0]};
          3'd6:    a = '{addr: {1'b0, r.channel, 1'b1},   data: r.word_count[15:8]};
          default: a = '{addr: REG_SINGLE_MASK,           data: {5'b0, 1'b0, r.channel}};
        endcase
      end
      CMD_WRITE_REG: a = '{addr: r.reg_address, data: r.reg_write_data};
      CMD_READ_REG:  a = '{addr: r.reg_address, data: 8'h00};
      default:       a = '{addr: 4'h0, data: 8'h00};
    endcase
    return a;
  endfunction

  // Index of the final access; the unmask write is appended only on request.
  function automatic logic [2:0] final_step(input request_t r);
    if (r.command == CMD_PROGRAM_CHANNEL) return r.unmask ? 3'd7 : 3'd6;
    return 3'd0;
  endfunction

endpackage

// File: rtl/kf8237_bus_initiator_if.sv
// Pin-level bus between the CPU-side initiator (master) and the KF8237 register port (slave).
interface kf8237_bus_initiator_if;
  logic       chip_select_n;
  logic       io_read_n;
  logic       io_write_n;
  logic [3:0] address_out;
  logic [7:0] data_bus_out;
  logic [7:0] data_bus_in;
  logic       bus_locked;

  modport master (
    output chip_select_n, io_read_n, io_write_n, address_out, data_bus_out,
    input  data_bus_in, bus_locked
  );

  modport slave (
    input  chip_select_n, io_read_n, io_write_n, address_out, data_bus_out,
    output data_bus_in, bus_locked
  );
endinterface

// File: rtl/kf8237_bus_cycle.sv
// Runs one register access: SETUP, STROBE (stretched while the DMA holds the bus),
// HOLD and GAP; captures read data on the strobe's releasing edge.
module kf8237_bus_cycle
  import kf8237_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES    = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req,
  output logic       ack,
  input  logic       is_read,
  input  logic [3:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  kf8237_bus_initiator_if.master bus
);

  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] GAP_LAST    = 4'(GAP_CYCLES - 1);

  phase_e     phase, phase_next;
  logic [3:0] count, count_next;
  logic       capture;

  // NOTE: sequential state uses <= so every flop samples the pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase <= PH_IDLE;
      count <= '0;
      rdata <= '0;
    end else begin
      phase <= phase_next;
      count <= count_next;
      if (capture) rdata <= bus.data_bus_in;
    end
  end

  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a signal unassigned (no latch).
    phase_next = phase;
    count_next = count;
    capture    = 1'b0;
    ack        = 1'b0;
    case (phase)
      PH_IDLE: if (req && !bus.bus_locked) phase_next = PH_SETUP;
      PH_SETUP: begin
        phase_next = PH_STROBE;
        count_next = '0;
      end
      PH_STROBE: begin
        if (count != STROBE_LAST) begin
          count_next = count + 4'd1;
        end else if (!bus.bus_locked) begin
          phase_next = PH_HOLD;
          capture    = is_read;
        end
      end
      PH_HOLD: begin
        phase_next = PH_GAP;
        count_next = '0;
      end
      PH_GAP: begin
        if (count != GAP_LAST) begin
          count_next = count + 4'd1;
        end else begin
          // A follow-on access chains straight into SETUP so the gap is exactly GAP_CYCLES.
          ack        = 1'b1;
          phase_next = (req && !bus.bus_locked) ? PH_SETUP : PH_IDLE;
        end
      end
      default: phase_next = PH_IDLE;
    endcase
  end

  assign bus.chip_select_n = !(phase inside {PH_SETUP, PH_STROBE, PH_HOLD});
  assign bus.io_read_n     = !((phase == PH_STROBE) && is_read);
  assign bus.io_write_n    = !((phase == PH_STROBE) && !is_read);
  assign bus.address_out   = addr;
  assign bus.data_bus_out  = wdata;

endmodule

// File: rtl/kf8237_bus_initiator.sv
// CPU-side initiator for the KF8237: latches a command and sequences one access
// (WRITE_REG/READ_REG) or the full channel-programming write sequence.
module kf8237_bus_initiator
  import kf8237_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES    = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  command,
  input  logic [1:0]  channel,
  input  logic [7:0]  mode,
  input  logic [15:0] base_address,
  input  logic [15:0] word_count,
  input  logic        unmask,
  input  logic [3:0]  reg_address,
  input  logic [7:0]  reg_write_data,
  kf8237_bus_initiator_if.master bus,
  output logic        busy,
  output logic        done,
  output logic [7:0]  read_data
);

  seq_e       state, state_next;
  request_t   incoming, req_q;
  access_t    access_q;
  logic [2:0] step;
  logic       accept, advance, last_access, ack, cycle_req;

  assign incoming = '{
    command:        command_e'(command),
    channel:        channel,
    mode:           mode,
    base_address:   base_address,
    word_count:     word_count,
    unmask:         unmask,
    reg_address:    reg_address,
    reg_write_data: reg_write_data
  };

  assign last_access = (step == final_step(req_q));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= SEQ_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    advance    = 1'b0;
    case (state)
      SEQ_RUN: begin
        if (ack) begin
          if (last_access) state_next = SEQ_DONE;
          else             advance    = 1'b1;
        end
      end
      default: begin
        // IDLE and DONE both take a new command; a reserved code is dropped silently.
        state_next = SEQ_IDLE;
        if (start && (incoming.command != CMD_RESERVED)) begin
          accept     = 1'b1;
          state_next = SEQ_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_q    <= '0;
      step     <= '0;
      access_q <= '0;
    end else if (accept) begin
      req_q    <= incoming;
      step     <= '0;
      access_q <= step_access(incoming, 3'd0);
    end else if (advance) begin
      step     <= step + 3'd1;
      access_q <= step_access(req_q, step + 3'd1);
    end
  end

  // Drop the request during the final GAP cycle so the access engine returns to idle.
  assign cycle_req = (state == SEQ_RUN) && !(ack && last_access);
  assign busy      = (state == SEQ_RUN);
  assign done      = (state == SEQ_DONE);

  kf8237_bus_cycle #(
    .STROBE_CYCLES(STROBE_CYCLES),
    .GAP_CYCLES   (GAP_CYCLES)
  ) u_bus_cycle (
    .clock  (clock),
    .reset_n(reset_n),
    .req    (cycle_req),
    .ack    (ack),
    .is_read(req_q.command == CMD_READ_REG),
    .addr   (access_q.addr),
    .wdata  (access_q.data),
    .rdata  (read_data),
    .bus    (bus)
  );

endmodule

// File: tb/tb_kf8237_bus_initiator.sv
// Self-checking bench: directed plan steps plus randomized commands, checked against
// an expected write list and a register-level DMA model driven from the bus pins.
module tb_kf8237_bus_initiator;
  import kf8237_pkg::*;

  localparam int S = 2;
  localparam int G = 1;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  command;
  logic [1:0]  channel;
  logic [7:0]  mode;
  logic [15:0] base_address;
  logic [15:0] word_count;
  logic        unmask;
  logic [3:0]  reg_address;
  logic [7:0]  reg_write_data;
  logic        busy;
  logic        done;
  logic [7:0]  read_data;

  kf8237_bus_initiator_if bus();

  kf8237_bus_initiator #(.STROBE_CYCLES(S), .GAP_CYCLES(G)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .command       (command),
    .channel       (channel),
    .mode          (mode),
    .base_address  (base_address),
    .word_count    (word_count),
    .unmask        (unmask),
    .reg_address   (reg_address),
    .reg_write_data(reg_write_data),
    .bus           (bus),
    .busy          (busy),
    .done          (done),
    .read_data     (read_data)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // DMA-side model: read data only while the read strobe is low, junk otherwise.
  logic [7:0]  dma_rdata;
  assign bus.data_bus_in = bus.io_read_n ? 8'hEE : dma_rdata;

  logic [15:0] dma_base [4];
  logic [15:0] dma_count[4];
  logic [7:0]  dma_mode [4];
  logic [3:0]  dma_mask;
  logic        dma_ff;
  logic [11:0] wr_q[$];
  logic [11:0] exp_q[$];

  int lat, rd_low, wr_low, cs_low, n;
  logic [7:0] rd_at_done;
  int lock_lo, lock_hi, extra_start;
  logic strobe_lock_chk, found, activity;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic dma_write(input logic [3:0] a, input logic [7:0] d);
    wr_q.push_back({a, d});
    if (a < 4'h8) begin
      if (!a[0]) begin
        if (dma_ff) dma_base[a[2:1]][15:8] = d; else dma_base[a[2:1]][7:0] = d;
      end else begin
        if (dma_ff) dma_count[a[2:1]][15:8] = d; else dma_count[a[2:1]][7:0] = d;
      end
      dma_ff = ~dma_ff;
    end else begin
      case (a)
        4'hA: dma_mask[d[1:0]] = d[2];
        4'hB: dma_mode[d[1:0]] = d;
        4'hC: dma_ff = 1'b0;
        4'hD: begin dma_mask = 4'hF; dma_ff = 1'b0; end
        4'hE: dma_mask = 4'h0;
        4'hF: dma_mask = d[3:0];
        default: ;
      endcase
    end
  endtask

  // A write commits on the rising edge of the write strobe while selected.
  always @(posedge bus.io_write_n)
    if (reset_n === 1'b1 && bus.chip_select_n === 1'b0)
      dma_write(bus.address_out, bus.data_bus_out);

  task automatic expect_program(input logic [1:0] ch, input logic [7:0] md,
                                input logic [15:0] base, input logic [15:0] cnt, input logic um);
    exp_q = {};
    exp_q.push_back({4'hA, 5'b0, 1'b1, ch});
    exp_q.push_back({4'hC, 8'h00});
    exp_q.push_back({4'hB, md[7:2], ch});
    exp_q.push_back({1'b0, ch, 1'b0, base[7:0]});
    exp_q.push_back({1'b0, ch, 1'b0, base[15:8]});
    exp_q.push_back({1'b0, ch, 1'b1, cnt[7:0]});
    exp_q.push_back({1'b0, ch, 1'b1, cnt[15:8]});
    if (um) exp_q.push_back({4'hA, 6'b0, ch});
  endtask

  function automatic logic lock_at(input int e);
    return (e >= lock_lo) && (e <= lock_hi);
  endfunction

  // Issue the command held on the inputs; edge 0 is the one that samples start.
  task automatic run(input int budget);
    wr_q = {};
    rd_low = 0; wr_low = 0; cs_low = 0; lat = -1;
    start = 1'b1;
    bus.bus_locked = lock_at(0);
    for (int e = 0; e < budget; e++) begin
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      if (e == extra_start) begin
        start = 1'b1; command = CMD_WRITE_REG; reg_address = 4'h3; reg_write_data = 8'h5A;
      end
      if (!bus.io_read_n)     rd_low++;
      if (!bus.io_write_n)    wr_low++;
      if (!bus.chip_select_n) cs_low++;
      if (strobe_lock_chk && lock_at(e)) check("strobe held while locked", 32'(bus.io_write_n), 0);
      if (e == 0) check("busy after start", 32'(busy), 1);
      bus.bus_locked = lock_at(e + 1);
      if (done) begin
        lat = e + 1;
        rd_at_done = read_data;
        check("busy low in done cycle", 32'(busy), 0);
        break;
      end
    end
    start = 1'b0;
    bus.bus_locked = 1'b0;
    check("done within budget", 32'(lat != -1), 1);
    @(negedge clock);
    check("done is one pulse", 32'(done), 0);
  endtask

  task automatic verify(input string name, input int exp_lat, input int exp_cs,
                        input int exp_wr, input int exp_rd);
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " cs low clks"}, 32'(cs_low), 32'(exp_cs));
    check({name, " wr low clks"}, 32'(wr_low), 32'(exp_wr));
    check({name, " rd low clks"}, 32'(rd_low), 32'(exp_rd));
    check({name, " write count"}, 32'(wr_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s write %0d", name, i),
            (i < wr_q.size()) ? 32'(wr_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; command = '0; channel = '0; mode = '0;
    base_address = '0; word_count = '0; unmask = 1'b0; reg_address = '0; reg_write_data = '0;
    bus.bus_locked = 1'b0; dma_rdata = '0; rd_at_done = '0;
    lock_lo = 1000; lock_hi = -1; extra_start = -1; strobe_lock_chk = 1'b0;
    dma_mask = 4'hF; dma_ff = 1'b0;
    for (int c = 0; c < 4; c++) begin dma_base[c] = '0; dma_count[c] = '0; dma_mode[c] = '0; end

    repeat (2) @(negedge clock);
    check("reset cs_n", 32'(bus.chip_select_n), 1);
    check("reset rd_n", 32'(bus.io_read_n), 1);
    check("reset wr_n", 32'(bus.io_write_n), 1);
    check("reset addr", 32'(bus.address_out), 0);
    check("reset data", 32'(bus.data_bus_out), 0);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset read_data", 32'(read_data), 0);
    reset_n = 1'b1;
    @(negedge clock);

    // Channel 2 programming with unmask
    command = CMD_PROGRAM_CHANNEL; channel = 2'd2; mode = 8'h48;
    base_address = 16'h1234; word_count = 16'h00FF; unmask = 1'b1;
    expect_program(2'd2, 8'h48, 16'h1234, 16'h00FF, 1'b1);
    run(100);
    verify("prog unmask", 2 + 8 * (2 + S + G), 8 * (2 + S), 8 * S, 0);
    check("ch2 base", 32'(dma_base[2]), 32'h1234);
    check("ch2 count", 32'(dma_count[2]), 32'h00FF);
    check("ch2 mode", 32'(dma_mode[2]), 32'h4A);
    check("ch2 unmasked", 32'(dma_mask[2]), 0);

    // Same without unmask: seven writes, mask stays set
    unmask = 1'b0; command = CMD_PROGRAM_CHANNEL;
    expect_program(2'd2, 8'h48, 16'h1234, 16'h00FF, 1'b0);
    run(100);
    verify("prog masked", 2 + 7 * (2 + S + G), 7 * (2 + S), 7 * S, 0);
    check("ch2 still masked", 32'(dma_mask[2]), 1);

    // Single read
    command = CMD_READ_REG; reg_address = 4'h8; dma_rdata = 8'h0F; exp_q = {};
    run(50);
    verify("read", 7, 2 + S, 0, S);
    check("read_data at done", 32'(rd_at_done), 32'h0F);

    // Write stretched by a 5-clock lock raised in the first strobe clock
    command = CMD_WRITE_REG; reg_address = 4'hD; reg_write_data = 8'h00;
    exp_q = {}; exp_q.push_back({4'hD, 8'h00});
    lock_lo = 3; lock_hi = 7; strobe_lock_chk = 1'b1;
    run(50);
    verify("strobe lock", 7 + 4, 2 + S + 4, S + 4, 0);
    check("master clear applied", 32'(dma_mask), 32'hF);
    strobe_lock_chk = 1'b0;

    // Lock already held at start delays SETUP with chip select high
    command = CMD_WRITE_REG; reg_address = 4'hE; reg_write_data = 8'h00;
    exp_q = {}; exp_q.push_back({4'hE, 8'h00});
    lock_lo = 0; lock_hi = 3;
    run(50);
    verify("setup lock", 7 + 3, 2 + S, S, 0);
    check("clear mask applied", 32'(dma_mask), 0);
    lock_lo = 1000; lock_hi = -1;

    // start while busy is ignored
    command = CMD_PROGRAM_CHANNEL; channel = 2'd3; mode = 8'h95;
    base_address = 16'hBEEF; word_count = 16'h0102; unmask = 1'b1;
    expect_program(2'd3, 8'h95, 16'hBEEF, 16'h0102, 1'b1);
    extra_start = 10;
    run(100);
    extra_start = -1;
    verify("busy start", 2 + 8 * (2 + S + G), 8 * (2 + S), 8 * S, 0);
    repeat (10) @(negedge clock);
    check("no extra command", 32'(wr_q.size()), 8);

    // Reserved command is dropped
    command = CMD_RESERVED; start = 1'b1; activity = 1'b0;
    @(negedge clock);
    start = 1'b0;
    for (int e = 0; e < 10; e++) begin
      activity = activity | busy | done | !bus.chip_select_n;
      @(negedge clock);
    end
    check("reserved ignored", 32'(activity), 0);

    // Reset in the strobe of step 3, then a fresh program starts at step 0
    command = CMD_PROGRAM_CHANNEL; channel = 2'd1; mode = 8'h04;
    base_address = 16'hA55A; word_count = 16'h3C3C; unmask = 1'b1;
    wr_q = {}; start = 1'b1; found = 1'b0;
    for (int e = 0; e < 60; e++) begin
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      if (wr_q.size() == 3 && bus.io_write_n == 1'b0) begin found = 1'b1; break; end
    end
    check("reached step3 strobe", 32'(found), 1);
    reset_n = 1'b0;
    #1;
    check("mid reset cs_n", 32'(bus.chip_select_n), 1);
    check("mid reset wr_n", 32'(bus.io_write_n), 1);
    check("mid reset rd_n", 32'(bus.io_read_n), 1);
    check("mid reset busy", 32'(busy), 0);
    check("mid reset read_data", 32'(read_data), 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    expect_program(2'd1, 8'h04, 16'hA55A, 16'h3C3C, 1'b1);
    run(100);
    verify("after reset", 2 + 8 * (2 + S + G), 8 * (2 + S), 8 * S, 0);
    check("ch1 base", 32'(dma_base[1]), 32'hA55A);

    // Randomized commands against the reference list and DMA register model
    for (int it = 0; it < 8; it++) begin
      command = 2'($urandom_range(0, 2));
      channel = 2'($urandom_range(0, 3));
      mode = 8'($urandom); base_address = 16'($urandom); word_count = 16'($urandom);
      unmask = 1'($urandom_range(0, 1));
      reg_address = 4'($urandom); reg_write_data = 8'($urandom); dma_rdata = 8'($urandom);
      exp_q = {};
      if (command == CMD_PROGRAM_CHANNEL)
        expect_program(channel, mode, base_address, word_count, unmask);
      else if (command == CMD_WRITE_REG)
        exp_q.push_back({reg_address, reg_write_data});
      n = exp_q.size();
      run(100);
      if (command == CMD_READ_REG) begin
        verify($sformatf("rand%0d read", it), 7, 2 + S, 0, S);
        check($sformatf("rand%0d read_data", it), 32'(rd_at_done), 32'(dma_rdata));
      end else begin
        verify($sformatf("rand%0d", it), 2 + n * (2 + S + G), n * (2 + S), n * S, 0);
      end
      if (command == CMD_PROGRAM_CHANNEL) begin
        check($sformatf("rand%0d base", it), 32'(dma_base[channel]), 32'(base_address));
        check($sformatf("rand%0d count", it), 32'(dma_count[channel]), 32'(word_count));
        check($sformatf("rand%0d mode", it), 32'(dma_mode[channel]), 32'({mode[7:2], channel}));
        check($sformatf("rand%0d mask", it), 32'(dma_mask[channel]), 32'(!unmask));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
